// File: rtl/br_resolve_pkg.sv
// Shared types and the commit-queue age helper for branch resolution.
package br_resolve_pkg;

    localparam int LNC  = 5;
    localparam int XLEN = 64;
    localparam int DECW = 4;

    typedef logic [LNC-1:0] cidx_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-2:0] pc;
        logic            is_short;
        logic [DECW-2:0] dec;
        cidx_t           addr;
    } redirect_t;

    // Distance from the commit head; smaller means older.
    function automatic cidx_t age(input cidx_t idx, input cidx_t head);
        return cidx_t'(idx - head);
    endfunction

endpackage

// File: rtl/br_age_select.sv
// Combinational picker of the oldest asserted mispredict report.
module br_age_select
    import br_resolve_pkg::*;
#(
    parameter int NALU = 2,
    parameter int LW   = (NALU > 1) ? $clog2(NALU) : 1
) (
    input  logic [NALU-1:0]     en_i,
    input  logic [NALU*LNC-1:0] addr_i,
    input  cidx_t               head_i,
    output logic                valid_o,
    output logic [LW-1:0]       lane_o,
    output cidx_t               age_o
);

    cidx_t a;

    // Strict compare keeps the lowest lane on equal ages.
    always_comb begin
        valid_o = 1'b0;
        lane_o  = '0;
        age_o   = '0;
        a       = '0;
        for (int i = 0; i < NALU; i++) begin
            a = age(addr_i[i*LNC +: LNC], head_i);
            if (en_i[i] && (!valid_o || a < age_o)) begin
                valid_o = 1'b1;
                lane_o  = LW'(i);
                age_o   = a;
            end
        end
    end

endmodule

// File: rtl/br_resolve.sv
// Oldest-redirect collector with kill-mask broadcast and fetch handshake.
// Optional counters enabled by BR_RESOLVE_STATS_EN.
module br_resolve
    import br_resolve_pkg::*;
#(
    parameter int NALU     = 2,
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = LNC,
    parameter int RV       = XLEN,
    parameter int BDEC     = DECW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NALU-1:0]         br_enable,
    input  logic [NALU*LNCOMMIT-1:0] br_addr,
    input  logic [NALU*(RV-1)-1:0]  br_target,
    input  logic [NALU-1:0]         br_short,
    input  logic [NALU*(BDEC-1)-1:0] br_dec,
    input  logic [LNCOMMIT-1:0]     commit_head,
    input  logic [LNCOMMIT-1:0]     commit_tail,
    input  logic                    trap_flush,
    output logic [NCOMMIT-1:0]      commit_kill,
    output logic                    redirect_valid,
    input  logic                    redirect_ready,
    output logic [RV-2:0]           redirect_pc,
    output logic                    redirect_short,
    output logic [BDEC-2:0]         redirect_dec
`ifdef BR_RESOLVE_STATS_EN
    ,
    output logic [31:0]             stat_redirects,
    output logic [31:0]             stat_replaced
`endif
);

    localparam int LW = (NALU > 1) ? $clog2(NALU) : 1;

    state_e           state_q, state_d;
    redirect_t        red_q, red_d, red_new;
    logic [NCOMMIT-1:0] kill_q, kill_d, mask;

    logic             sel_v;
    logic [LW-1:0]    sel_lane;
    cidx_t            sel_age;
    cidx_t            pend_age;
    cidx_t            ai;
    logic [LNC:0]     tail_age;
    logic             take;

    br_age_select #(.NALU(NALU)) u_sel (
        .en_i    (br_enable),
        .addr_i  (br_addr),
        .head_i  (commit_head),
        .valid_o (sel_v),
        .lane_o  (sel_lane),
        .age_o   (sel_age)
    );

    assign pend_age = age(red_q.addr, commit_head);
    assign take     = sel_v && (state_q == IDLE || sel_age < pend_age);
    assign tail_age = (commit_tail == commit_head) ? (LNC+1)'(NCOMMIT)
                                                   : {1'b0, age(commit_tail, commit_head)};

    always_comb begin
        red_new.pc       = br_target[int'(sel_lane)*(RV-1) +: RV-1];
        red_new.is_short = br_short[sel_lane];
        red_new.dec      = br_dec[int'(sel_lane)*(BDEC-1) +: BDEC-1];
        red_new.addr     = br_addr[int'(sel_lane)*LNCOMMIT +: LNCOMMIT];
    end

    // Kill strictly between the branch and the tail; the branch survives.
    always_comb begin
        mask = '0;
        ai   = '0;
        for (int i = 0; i < NCOMMIT; i++) begin
            ai      = age(cidx_t'(i), commit_head);
            mask[i] = (sel_age < ai) && ({1'b0, ai} < tail_age);
        end
    end

    always_comb begin
        state_d = state_q;
        red_d   = red_q;
        kill_d  = '0;
        if (trap_flush) begin
            state_d = IDLE;
        end else if (take) begin
            state_d = PEND;
            red_d   = red_new;
            kill_d  = mask;
        end else if (state_q == PEND && redirect_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            red_q   <= '0;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            red_q   <= red_d;
            kill_q  <= kill_d;
        end
    end

    assign redirect_valid = (state_q == PEND);
    assign commit_kill    = kill_q;
    assign redirect_pc    = red_q.pc;
    assign redirect_short = red_q.is_short;
    assign redirect_dec   = red_q.dec;

`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] redir_q, repl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redir_q <= '0;
            repl_q  <= '0;
        end else if (!trap_flush && state_q == PEND) begin
            if (redirect_ready) redir_q <= redir_q + 32'd1;
            if (take)           repl_q  <= repl_q + 32'd1;
        end
    end

    assign stat_redirects = redir_q;
    assign stat_replaced  = repl_q;
`endif

endmodule
